// File: rtl/seg_scan_driver.sv
// Time-multiplexes the eight nibbles of a 32-bit word onto one 7-segment decoder input.
// Drives active-low digit enables, with double buffering so a new word only appears at a frame boundary.
module seg_scan_driver #(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8,
    parameter int LZ_BLANK   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        value_valid,
    output logic [31:0] digit_data,
    output logic [7:0]  an,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);
    localparam int             PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]       prescaler;
    logic [31:0]         pending;
    logic [31:0]         frame;
    logic                tick;
    logic                wrap;
    logic                blank;
    logic [NUM_DIGITS:0] tail_zero;

    assign tick = (prescaler == PMAX);
    assign wrap = tick && (digit_idx == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            pending    <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick)
                digit_idx <= wrap ? 3'd0 : digit_idx + 3'd1;
            if (value_valid)
                pending <= value_in;
            // A strobe landing on the wrap tick goes straight into the new frame.
            if (wrap)
                frame <= value_valid ? value_in : pending;
            frame_done <= wrap;
        end
    end

    // tail_zero[i]: nibbles i..NUM_DIGITS-1 of the displayed frame are all zero.
    assign tail_zero[NUM_DIGITS] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_tz
        assign tail_zero[g] = tail_zero[g+1] && (frame[4*g +: 4] == 4'h0);
    end

    assign blank = (LZ_BLANK != 0) && (digit_idx != 3'd0) && tail_zero[digit_idx];

    always_comb begin
        digit_data = {28'b0, frame[{digit_idx, 2'b00} +: 4]};
        an         = 8'hFF;
        if (!blank)
            an = ~(8'b1 << digit_idx);
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero blanking on and off) share stimulus.
// Words expected on the next frame go into a queue and are checked digit by digit at each frame start.
module tb_seg_scan_driver;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value_in;
    logic        value_valid;
    logic [31:0] digit_data, digit_data_nb;
    logic [7:0]  an, an_nb;
    logic [2:0]  digit_idx, digit_idx_nb;
    logic        frame_done, frame_done_nb;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(8), .LZ_BLANK(1)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .digit_data(digit_data), .an(an), .digit_idx(digit_idx), .frame_done(frame_done));

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(8), .LZ_BLANK(0)) dut_nb (
        .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .digit_data(digit_data_nb), .an(an_nb), .digit_idx(digit_idx_nb), .frame_done(frame_done_nb));

    // Drive a one-cycle strobe starting at the current negedge.
    task automatic strobe(input logic [31:0] v);
        value_in    = v;
        value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
    endtask

    // Scoreboard consumer: wait for a frame start, pop the expected word, check all eight digits.
    task automatic consume_frame(input string tag);
        logic [31:0] w;
        logic [7:0]  ex_an, ex_an_nb;
        logic [3:0]  ex_nib;
        logic        tz;
        int          n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL %s frame_done timeout: got %b want 1", tag, frame_done);
            return;
        end
        w = sb_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (CLK_DIV) @(negedge clk);
            tz = 1'b1;
            for (int j = i; j < 8; j++)
                if (w[4*j +: 4] != 4'h0) tz = 1'b0;
            ex_nib   = w[4*i +: 4];
            ex_an_nb = ~(8'b1 << i);
            ex_an    = (i != 0 && tz) ? 8'hFF : ex_an_nb;
            checks++;
            if (digit_idx !== 3'(i)) begin
                errors++;
                $display("FAIL %s digit_idx d%0d: got %0d want %0d", tag, i, digit_idx, i);
            end
            checks++;
            if (digit_data !== {28'b0, ex_nib}) begin
                errors++;
                $display("FAIL %s digit_data d%0d: got %h want %h", tag, i, digit_data, ex_nib);
            end
            checks++;
            if (an !== ex_an) begin
                errors++;
                $display("FAIL %s an d%0d: got %h want %h", tag, i, an, ex_an);
            end
            checks++;
            if (digit_data_nb !== {28'b0, ex_nib}) begin
                errors++;
                $display("FAIL %s digit_data_nb d%0d: got %h want %h", tag, i, digit_data_nb, ex_nib);
            end
            checks++;
            if (an_nb !== ex_an_nb) begin
                errors++;
                $display("FAIL %s an_nb d%0d: got %h want %h", tag, i, an_nb, ex_an_nb);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; value_in = '0; value_valid = 1'b0;
        #12;
        checks++;
        if (an !== 8'hFE || digit_data !== 32'h0 || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got an=%h data=%h idx=%0d fd=%b want FE 0 0 0",
                     an, digit_data, digit_idx, frame_done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int n;
        sb_q.push_back(32'h0);
        consume_frame("idle");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        checks++;
        if (n != CLK_DIV) begin
            errors++;
            $display("FAIL idle_frame_period: got %0d want %0d", 7*CLK_DIV + n, 8*CLK_DIV);
        end
    endtask

    task automatic test_midframe_update();
        int n;
        repeat (10) @(negedge clk);
        strobe(32'h1234ABCD);
        sb_q.push_back(32'h1234ABCD);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            checks++;
            if (digit_data !== 32'h0 || digit_data_nb !== 32'h0) begin
                errors++;
                $display("FAIL old_frame_held: got %h/%h want 0", digit_data, digit_data_nb);
            end
        end while (digit_idx != 3'd7 && n < 100);
        consume_frame("midframe");
    endtask

    task automatic test_lz_blank();
        @(negedge clk);
        strobe(32'h000000A5);
        sb_q.push_back(32'h000000A5);
        consume_frame("lz_a5");
    endtask

    task automatic test_last_wins();
        @(negedge clk);
        strobe(32'h11111111);
        @(negedge clk);
        strobe(32'h22222222);
        sb_q.push_back(32'h22222222);
        consume_frame("last_wins");
    endtask

    task automatic test_bypass();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        // frame_done cycle is slot 0 of digit 0; the wrap tick is the last slot of digit 7.
        repeat (8*CLK_DIV - 1) @(negedge clk);
        checks++;
        if (digit_idx !== 3'd7) begin
            errors++;
            $display("FAIL bypass_align: got idx %0d want 7", digit_idx);
        end
        strobe(32'hDEADBEEF);
        sb_q.push_back(32'hDEADBEEF);
        consume_frame("bypass");
        sb_q.push_back(32'hDEADBEEF);
        consume_frame("bypass_pending");
    endtask

    task automatic test_reset_midframe();
        int n;
        @(negedge clk);
        strobe(32'hFFFFFFFF);
        sb_q.push_back(32'hFFFFFFFF);
        consume_frame("all_f");
        n = 0;
        while (digit_idx != 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (digit_idx !== 3'd5 || digit_data !== 32'hF) begin
            errors++;
            $display("FAIL pre_reset: got idx %0d data %h want 5 F", digit_idx, digit_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (an !== 8'hFE || digit_data !== 32'h0 || digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got an=%h data=%h idx=%0d want FE 0 0", an, digit_data, digit_idx);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        checks++;
        if (digit_idx !== 3'd1 || an !== 8'hFF || an_nb !== 8'hFD) begin
            errors++;
            $display("FAIL restart_scan: got idx %0d an %h an_nb %h want 1 FF FD", digit_idx, an, an_nb);
        end
        sb_q.push_back(32'h0);
        consume_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_midframe_update();
        test_lz_blank();
        test_last_wins();
        test_bypass();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
